// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : coin_acceptor
// Purpose  : Synchronises and debounces raw coin sensors, buffers coins in a
//            small FIFO and issues paced coin5/coin10 pulses downstream.
//            Define COIN_ACCEPTOR_TOTAL_EN to add the saturating total[7:0].
// Revision : 1.0  initial release
// ============================================================================
module coin_acceptor #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               raw_coin5,
  input  logic                               raw_coin10,
  input  logic                               hold,
  output logic                               coin5,
  output logic                               coin10,
  output logic [1:0]                         coin_reject,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending
`ifdef COIN_ACCEPTOR_TOTAL_EN
  ,
  output logic [7:0]                         total
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // Bit 0 is the 5-unit channel, bit 1 the 10-unit channel throughout.
  logic [1:0]     sync_q    [SYNC_STAGES];
  logic [1:0]     sync_d    [SYNC_STAGES];
  logic [1:0]     synced_w;
  logic [DW-1:0]  cnt_q     [2];
  logic [DW-1:0]  cnt_d     [2];
  logic [DW-1:0]  arm_cnt_q [2];
  logic [DW-1:0]  arm_cnt_d [2];
  logic [1:0]     deb_q, deb_d;
  logic [1:0]     armed_q, armed_d;
  logic [1:0]     event_q, event_d;

  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic [PW-1:0]         free_w;
  logic [1:0]            n_push_w;
  logic [1:0]            reject_q, reject_d;
  logic                  pop_w;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          coin5_q, coin5_d;
  logic          coin10_q, coin10_d;

  always_comb begin
    sync_d[0] = {raw_coin10, raw_coin5};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign synced_w = sync_q[SYNC_STAGES-1];

  // Arming needs the channel quiet at both the synced and debounced level, so
  // a sensor stuck high through reset never reads as a fresh insertion.
  always_comb begin
    deb_d   = deb_q;
    armed_d = armed_q;
    for (int c = 0; c < 2; c++) begin
      cnt_d[c]     = '0;
      arm_cnt_d[c] = '0;
      if (synced_w[c] != deb_q[c]) begin
        if (cnt_q[c] == DEB_LAST) begin
          deb_d[c] = synced_w[c];
        end else begin
          cnt_d[c] = cnt_q[c] + DW'(1);
        end
      end
      if (!armed_q[c] && !deb_q[c] && !synced_w[c]) begin
        if (arm_cnt_q[c] == DEB_LAST) begin
          armed_d[c] = 1'b1;
        end else begin
          arm_cnt_d[c] = arm_cnt_q[c] + DW'(1);
        end
      end
    end
    event_d = armed_q & deb_d & ~deb_q;
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    pop_w    = 1'b0;
    coin5_d  = 1'b0;
    coin10_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !hold) begin
          pop_w    = 1'b1;
          coin5_d  = ~mem_q[rd_ptr_q];
          coin10_d = mem_q[rd_ptr_q];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A same-cycle pop frees its slot before the 5 and then the 10 claim space.
  always_comb begin
    mem_d    = mem_q;
    reject_d = '0;
    n_push_w = '0;
    free_w   = PW'(FIFO_DEPTH) - count_q + PW'(pop_w);
    if (event_q[0]) begin
      if (free_w != '0) begin
        mem_d[wr_ptr_q] = 1'b0;
        n_push_w        = 2'd1;
      end else begin
        reject_d[0] = 1'b1;
      end
    end
    if (event_q[1]) begin
      if (free_w > PW'(n_push_w)) begin
        mem_d[wr_ptr_q + AW'(n_push_w)] = 1'b1;
        n_push_w                        = n_push_w + 2'd1;
      end else begin
        reject_d[1] = 1'b1;
      end
    end
    wr_ptr_d = wr_ptr_q + AW'(n_push_w);
    rd_ptr_d = rd_ptr_q + AW'(pop_w);
    count_d  = count_q + PW'(n_push_w) - PW'(pop_w);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int c = 0; c < 2; c++) begin
        cnt_q[c]     <= '0;
        arm_cnt_q[c] <= '0;
      end
      deb_q    <= '0;
      armed_q  <= '0;
      event_q  <= '0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      reject_q <= '0;
      state_q  <= S_IDLE;
      gap_q    <= '0;
      coin5_q  <= 1'b0;
      coin10_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      deb_q     <= deb_d;
      armed_q   <= armed_d;
      event_q   <= event_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      reject_q  <= reject_d;
      state_q   <= state_d;
      gap_q     <= gap_d;
      coin5_q   <= coin5_d;
      coin10_q  <= coin10_d;
    end
  end

  assign coin5       = coin5_q;
  assign coin10      = coin10_q;
  assign coin_reject = reject_q;
  assign pending     = count_q;

`ifdef COIN_ACCEPTOR_TOTAL_EN
  logic [7:0] total_q, total_d;
  logic [8:0] total_sum_w;

  // The issue pulse is high only during ISSUE, so it doubles as the weight.
  always_comb begin
    total_sum_w = {1'b0, total_q} + {7'd0, coin10_q, coin5_q};
    total_d     = total_sum_w[8] ? 8'hFF : total_sum_w[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total = total_q;
`endif

endmodule
`default_nettype wire
